// File: rtl/peri_pwm_fader_if.sv
// peri_pwm_fader_if: host wishbone port plus the shared downstream bus to the PWM channel bank
interface peri_pwm_fader_if #(parameter int NCH = 4);
  logic wb_we;
  logic wb_stb;
  logic wb_ack;
  logic [3:0] wb_adr;
  logic [7:0] wb_wdat;
  logic [7:0] wb_rdat;
  logic [NCH-1:0] ch_stb;
  logic [NCH-1:0] ch_ack;
  logic ch_we;
  logic [7:0] ch_dat;
  modport slave(
    input wb_we, wb_stb, wb_adr, wb_wdat, ch_ack,
    output wb_ack, wb_rdat, ch_stb, ch_we, ch_dat
  );
  modport master(
    output wb_we, wb_stb, wb_adr, wb_wdat, ch_ack,
    input wb_ack, wb_rdat, ch_stb, ch_we, ch_dat
  );
endinterface

// File: rtl/peri_pwm_fader.sv
// peri_pwm_fader: on each fade tick, walks the channels and steps each current duty toward its target
module peri_pwm_fader #(
  parameter int NCH = 4,
  parameter int TICK_DIV = 1024
) (
  input logic clk_i,
  input logic rst_ni,
  peri_pwm_fader_if.slave bus
);
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int CW = $clog2(256 * TICK_DIV + 1);
  localparam logic [3:0] NCH4 = 4'(NCH);
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);
  typedef enum logic [1:0] {IDLE, EVAL, WRITE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [7:0] tgt [NCH];
  logic [7:0] cur [NCH];
  logic [7:0] step, presc, nxt, nxt_nx, ct, cc, diff, calc;
  logic [2:0] sel;
  logic en, ovr, tick, busy, wr, ack, done, jump;
  logic [CW-1:0] cnt, per_m1;
  assign wr = bus.wb_stb & bus.wb_we;
  assign per_m1 = CW'((32'(presc) + 32'd1) * TICK_DIV - 1);
  assign tick = en && cnt == per_m1;
  assign busy = state != IDLE;
  assign ct = tgt[idx];
  assign cc = cur[idx];
  assign ack = bus.ch_ack[idx];
  assign done = idx == LAST;
  // magnitude compare against STEP cannot overshoot, so 0 and 255 land exactly
  assign diff = ct > cc ? ct - cc : cc - ct;
  assign jump = step == 8'd0 || diff <= step;
  assign calc = jump ? ct : ct > cc ? cc + step : cc - step;
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    nxt_nx = nxt;
    case (state)
      IDLE: if (tick) begin
        state_nx = EVAL;
        idx_nx = '0;
      end
      EVAL: if (!en) state_nx = IDLE;
      else if (ct == cc) begin
        state_nx = done ? IDLE : EVAL;
        idx_nx = done ? idx : idx + 1'b1;
      end else begin
        state_nx = WRITE;
        nxt_nx = calc;
      end
      WRITE: if (ack) begin
        state_nx = (done || !en) ? IDLE : EVAL;
        idx_nx = (done || !en) ? idx : idx + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign bus.ch_stb = state == WRITE ? NCH'(1) << idx : '0;
  assign bus.ch_we = state == WRITE;
  assign bus.ch_dat = state == WRITE ? nxt : 8'd0;
  assign bus.wb_ack = bus.wb_stb;
  assign bus.wb_rdat = bus.wb_adr < NCH4 ? tgt[bus.wb_adr[IW-1:0]] :
    bus.wb_adr == 4'd8 ? step :
    bus.wb_adr == 4'd9 ? presc :
    bus.wb_adr == 4'd10 ? {7'd0, en} :
    bus.wb_adr == 4'd11 ? {6'd0, ovr, busy} :
    bus.wb_adr == 4'd12 ? {5'd0, sel} :
    bus.wb_adr == 4'd13 && {1'b0, sel} < NCH4 ? cur[sel[IW-1:0]] : 8'd0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      idx <= '0;
      nxt <= '0;
      step <= '0;
      presc <= '0;
      en <= 1'b0;
      ovr <= 1'b0;
      sel <= '0;
      cnt <= '0;
      for (int i = 0; i < NCH; i++) begin
        tgt[i] <= '0;
        cur[i] <= '0;
      end
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      nxt <= nxt_nx;
      cnt <= (!en || (wr && bus.wb_adr == 4'd9) || tick) ? '0 : cnt + 1'b1;
      ovr <= (tick && busy) || (ovr && !(wr && bus.wb_adr == 4'd11 && bus.wb_wdat[1]));
      if (wr && bus.wb_adr == 4'd8) step <= bus.wb_wdat;
      if (wr && bus.wb_adr == 4'd9) presc <= bus.wb_wdat;
      if (wr && bus.wb_adr == 4'd10) en <= bus.wb_wdat[0];
      if (wr && bus.wb_adr == 4'd12) sel <= bus.wb_wdat[2:0];
      for (int i = 0; i < NCH; i++) begin
        if (wr && bus.wb_adr == 4'(i)) tgt[i] <= bus.wb_wdat;
        if (state == WRITE && ack && idx == IW'(i)) cur[i] <= nxt;
      end
    end
endmodule
